serial_wb_master: RTL and testbench
===================================

Name: serial_wb_master

Overview:
- Byte-stream-to-Wishbone bridge.
- Consumes command frames from the debug serial receiver and issues single 16-bit Wishbone classic cycles on the board control bus.
- Returns status/read data as a byte stream to the serial transmitter.
- Sits directly upstream of the control-bus slaves (system block, scratchpad, counters) and is the master that drives them.

Parameters:
- BUS_TIMEOUT, 16'd1024, cycles cyc_o may stay high without ack_i before the cycle is aborted.
- FRAME_TIMEOUT, 16'd65535, idle cycles allowed between bytes of one frame before the partial frame is discarded.

Ports:
- wb_clk_i  input  1  system clock; all logic on its rising edge.
- wb_rst_i  input  1  synchronous active-high reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data valid; byte is consumed when rx_valid & rx_ready.
- rx_ready  output  1  bridge can accept a byte.
- tx_data  output  8  response byte.
- tx_valid  output  1  tx_data valid; held with stable tx_data until tx_ready.
- tx_ready  input  1  transmitter accepts byte.
- wb_cyc_o  output  1  Wishbone cycle.
- wb_stb_o  output  1  Wishbone strobe.
- wb_we_o  output  1  write enable.
- wb_sel_o  output  2  byte selects.
- wb_adr_o  output  32  byte address.
- wb_dat_o  output  16  write data.
- wb_dat_i  input  16  read data.
- wb_ack_i  input  1  slave acknowledge.
- busy  output  1  high in any state other than CMD.

Behaviour:
- Interface: one clock (wb_clk_i); reset wb_rst_i is synchronous, active-high.
- Reset values:
  - state=CMD.
  - wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0.
  - tx_valid=0, tx_data=0, rx_ready=0 on the reset cycle, then 1.
  - Counters cleared.
- Frame format (all fields MSB first):
  - Byte 0 = command: bit7 = we, bits[1:0] = sel, bits[6:2] ignored.
  - Bytes 1-4 = address.
  - Write frames only: bytes 5-6 = data.
- States:
  - CMD: rx_ready=1. On accepted byte, latch we/sel, clear byte count, go to ADDR.
  - ADDR: rx_ready=1. Shift bytes into wb_adr_o. After the 4th byte, go to WDATA if we, else BUS.
  - WDATA: rx_ready=1. Shift 2 bytes into wb_dat_o, then go to BUS.
  - BUS:
    - rx_ready=0. Entry cycle asserts cyc_o/stb_o/we_o/sel_o; they are held until ack_i is sampled high.
    - On ack: cyc_o/stb_o deassert on the next edge. Reads latch wb_dat_i on the ack cycle. status=8'h00.
    - Timeout counter increments each BUS cycle without ack. At BUS_TIMEOUT-1 with no ack: deassert cyc/stb, status=8'h01, read data forced to 16'h0000.
    - Either outcome goes to RESP.
  - RESP:
    - rx_ready=0. Sends status byte. Reads then send data[15:8], then data[7:0].
    - Each byte is held until tx_ready. The next byte is presented the cycle after the handshake.
    - After the last byte, tx_valid=0 and state returns to CMD.
- ack_i is ignored outside BUS. A late ack after timeout has no effect.
- ack_i on the first BUS cycle is valid; that gives the minimum 1-cycle slave latency.
- Frame timeout:
  - In ADDR/WDATA, a counter increments each cycle with no accepted byte and clears on each accepted byte.
  - When it reaches FRAME_TIMEOUT-1: return to CMD, no bus cycle, no response. wb_adr_o keeps its last value.
- rx_ready is registered. At most one byte is accepted per cycle.
- wb_rst_i mid-cycle (any state): all outputs return to reset values on the next edge, including dropping cyc_o mid-transaction. The pending response is lost.
- Latency: last frame byte accepted at cycle N → cyc_o high at N+1.

Test Plan:
- Write frame 80 00 00 00 08 12 34, slave acks 1 cycle after stb: cyc_o high 1 cycle after last byte, adr_o=0x00000008, dat_o=0x1234, sel_o=2'b00, we_o=1. Response single byte 0x00.
- Write frame 83 00 00 00 08 12 34: sel_o=2'b11, dat_o=0x1234. Then read frame 03 00 00 00 08 returns 00 12 34.
- Read 03 00 00 00 00 from slave returning 0xDEAD after 3-wait ack: tx bytes 00 DE AD. tx_ready held low 5 cycles before byte 2 → tx_data stays DE, no byte lost.
- Read to unmapped address, no ack ever: cyc_o drops after exactly BUS_TIMEOUT cycles. Response 01 00 00. Next frame processes normally.
- Frame 03 00 00 then FRAME_TIMEOUT idle cycles: back to CMD, no cyc_o. Following read frame executes with the new address.
- wb_rst_i pulsed while cyc_o high awaiting ack: next cycle cyc_o=0, tx_valid=0, busy=0. No response emitted.

Source files
------------

// File: rtl/serial_wb_master.sv
// Byte-stream to Wishbone classic bridge: decodes serial command frames,
// runs one 16-bit bus cycle per frame and streams back status/read data.
module serial_wb_master #(
    parameter logic [15:0] BUS_TIMEOUT   = 16'd1024,
    parameter logic [15:0] FRAME_TIMEOUT = 16'd65535
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [1:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        busy
);

    localparam logic [2:0] S_CMD   = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_BUS   = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]  state;
    logic        we_r;
    logic [1:0]  sel_r;
    logic [1:0]  bcnt;
    logic [15:0] fcnt;
    logic [15:0] tcnt;
    logic [15:0] rdata;
    logic        acc;
    logic        bus_done;

    assign acc      = rx_valid & rx_ready;
    assign busy     = (state != S_CMD);
    assign bus_done = wb_ack_i || (tcnt == BUS_TIMEOUT - 16'd1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= S_CMD;
            we_r     <= 1'b0;
            sel_r    <= 2'b00;
            bcnt     <= 2'd0;
            fcnt     <= 16'd0;
            tcnt     <= 16'd0;
            rdata    <= 16'd0;
            rx_ready <= 1'b0;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 2'b00;
            wb_adr_o <= 32'd0;
            wb_dat_o <= 16'd0;
        end else begin
            case (state)
                S_CMD: begin
                    rx_ready <= 1'b1;
                    if (acc) begin
                        we_r  <= rx_data[7];
                        sel_r <= rx_data[1:0];
                        bcnt  <= 2'd0;
                        fcnt  <= 16'd0;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (acc) begin
                        wb_adr_o <= {wb_adr_o[23:0], rx_data};
                        fcnt     <= 16'd0;
                        bcnt     <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            bcnt <= 2'd0;
                            if (we_r) begin
                                state <= S_WDATA;
                            end else begin
                                // Bus strobes launch on the same edge as the last byte
                                state    <= S_BUS;
                                rx_ready <= 1'b0;
                                tcnt     <= 16'd0;
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                wb_we_o  <= 1'b0;
                                wb_sel_o <= sel_r;
                            end
                        end
                    end else if (fcnt == FRAME_TIMEOUT - 16'd1) begin
                        state <= S_CMD;
                    end else begin
                        fcnt <= fcnt + 16'd1;
                    end
                end
                S_WDATA: begin
                    if (acc) begin
                        wb_dat_o <= {wb_dat_o[7:0], rx_data};
                        fcnt     <= 16'd0;
                        bcnt     <= bcnt + 2'd1;
                        if (bcnt == 2'd1) begin
                            bcnt     <= 2'd0;
                            state    <= S_BUS;
                            rx_ready <= 1'b0;
                            tcnt     <= 16'd0;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b1;
                            wb_sel_o <= sel_r;
                        end
                    end else if (fcnt == FRAME_TIMEOUT - 16'd1) begin
                        state <= S_CMD;
                    end else begin
                        fcnt <= fcnt + 16'd1;
                    end
                end
                S_BUS: begin
                    if (bus_done) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= 2'b00;
                        tx_valid <= 1'b1;
                        tx_data  <= wb_ack_i ? 8'h00 : 8'h01;
                        rdata    <= (wb_ack_i && !we_r) ? wb_dat_i : 16'h0000;
                        bcnt     <= 2'd0;
                        state    <= S_RESP;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                S_RESP: begin
                    if (tx_ready) begin
                        if (!we_r && bcnt == 2'd0) begin
                            tx_data <= rdata[15:8];
                            bcnt    <= 2'd1;
                        end else if (!we_r && bcnt == 2'd1) begin
                            tx_data <= rdata[7:0];
                            bcnt    <= 2'd2;
                        end else begin
                            tx_valid <= 1'b0;
                            rx_ready <= 1'b1;
                            state    <= S_CMD;
                        end
                    end
                end
                default: begin
                    state <= S_CMD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_wb_master.sv
// Scoreboard bench for serial_wb_master: frames in, Wishbone slave model,
// response bytes compared against a queue of expected values.
module tb_serial_wb_master;

    localparam logic [15:0] BT = 16'd16;
    localparam logic [15:0] FT = 16'd20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        cyc, stb, we;
    logic [1:0]  sel;
    logic [31:0] adr;
    logic [15:0] dat_o;
    logic [15:0] dat_i = 16'd0;
    logic        ack = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    logic [15:0] mem[16];
    int wait_n = 0;
    int wc = 0;

    always #5 clk = ~clk;

    serial_wb_master #(.BUS_TIMEOUT(BT), .FRAME_TIMEOUT(FT)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel),
        .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(dat_i),
        .wb_ack_i(ack), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Slave: mapped below 0x100, acks wait_n cycles after the first stb cycle
    always @(posedge clk) begin
        if (cyc && stb && !ack && adr < 32'h100) begin
            if (wc == wait_n) begin
                ack <= 1'b1;
                if (we) mem[adr[4:1]] <= dat_o;
                dat_i <= (adr[7:0] == 8'h00) ? 16'hDEAD : mem[adr[4:1]];
                wc <= 0;
            end else begin
                wc <= wc + 1;
            end
        end else begin
            ack <= 1'b0;
            wc <= 0;
        end
    end

    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                chk("tx_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                chk("tx_byte", 32'(tx_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("rx_ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                              input logic [15:0] d);
        send_byte(cmd);
        send_byte(a[31:24]);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        if (cmd[7]) begin
            send_byte(a[7:0]);
            send_byte(d[15:8]);
            chk("cyc_early", 32'(cyc), 32'd0);
            send_byte(d[7:0]);
        end else begin
            chk("cyc_early", 32'(cyc), 32'd0);
            send_byte(a[7:0]);
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("resp_drain", 32'(sb.size()), 32'd0);
        chk("resp_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        logic seen;
        repeat (2) @(negedge clk);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_txv", 32'(tx_valid), 32'd0);
        chk("rst_rxr", 32'(rx_ready), 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rxr_after_rst", 32'(rx_ready), 32'd1);

        // Write, sel 00, 1-cycle slave
        wait_n = 0;
        sb.push_back(8'h00);
        send_frame(8'h80, 32'h8, 16'h1234);
        chk("w1_cyc", 32'(cyc), 32'd1);
        chk("w1_adr", adr, 32'h8);
        chk("w1_dat", 32'(dat_o), 32'h1234);
        chk("w1_sel", 32'(sel), 32'd0);
        chk("w1_we", 32'(we), 32'd1);
        wait_resp();

        // Write sel 11 then read back
        sb.push_back(8'h00);
        send_frame(8'h83, 32'h8, 16'h1234);
        chk("w2_sel", 32'(sel), 32'd3);
        chk("w2_dat", 32'(dat_o), 32'h1234);
        wait_resp();
        sb.push_back(8'h00); sb.push_back(8'h12); sb.push_back(8'h34);
        send_frame(8'h03, 32'h8, 16'h0);
        chk("r1_we", 32'(we), 32'd0);
        chk("r1_sel", 32'(sel), 32'd3);
        wait_resp();

        // Read 0xDEAD with wait states, transmitter stalls before byte 2
        wait_n = 3;
        tx_ready = 1'b0;
        sb.push_back(8'h00); sb.push_back(8'hDE); sb.push_back(8'hAD);
        send_frame(8'h03, 32'h0, 16'h0);
        n = 0;
        while (!tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_txv", 32'(tx_valid), 32'd1);
        @(posedge clk); #1 tx_ready = 1'b1;
        @(posedge clk); #1 tx_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_data", 32'(tx_data), 32'hDE);
            chk("stall_valid", 32'(tx_valid), 32'd1);
        end
        @(posedge clk); #1 tx_ready = 1'b1;
        wait_resp();
        wait_n = 0;

        // Unmapped read: bus timeout
        sb.push_back(8'h01); sb.push_back(8'h00); sb.push_back(8'h00);
        send_frame(8'h03, 32'h2000, 16'h0);
        n = 0;
        while (cyc && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("bus_timeout_len", 32'(n), 32'(BT));
        wait_resp();
        sb.push_back(8'h00); sb.push_back(8'h12); sb.push_back(8'h34);
        send_frame(8'h03, 32'h8, 16'h0);
        wait_resp();

        // Partial frame abandoned by frame timeout
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        rx_valid = 1'b0;
        seen = 1'b0;
        repeat (int'(FT) - 1) begin
            @(negedge clk);
            seen = seen | cyc;
        end
        chk("ft_before", 32'(busy), 32'd1);
        @(negedge clk);
        seen = seen | cyc;
        chk("ft_after", 32'(busy), 32'd0);
        chk("ft_no_cyc", 32'(seen), 32'd0);
        sb.push_back(8'h00); sb.push_back(8'hDE); sb.push_back(8'hAD);
        send_frame(8'h03, 32'h0, 16'h0);
        chk("ft_new_adr", adr, 32'h0);
        wait_resp();

        // Reset while waiting for ack
        send_frame(8'h03, 32'h4000, 16'h0);
        repeat (3) @(negedge clk);
        chk("pre_rst_cyc", 32'(cyc), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cyc", 32'(cyc), 32'd0);
        chk("mid_rst_txv", 32'(tx_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (BT + 4) @(negedge clk);
        chk("rst_no_resp", 32'(tx_valid), 32'd0);
        sb.push_back(8'h00); sb.push_back(8'h12); sb.push_back(8'h34);
        send_frame(8'h03, 32'h8, 16'h0);
        wait_resp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

endmodule
